// File: rtl/i2c_init_seq.sv
// Table-driven I2C configuration sequencer: walks {dev, reg, val} entries from a
// synchronous ROM and issues each as a two-byte write, with delay entries and NACK retry.
module i2c_init_seq #(
    parameter int AW         = 6,
    parameter int RETRIES    = 3,
    parameter int DELAY_UNIT = 1000,
    parameter int AUTOSTART  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] tab_addr,
    input  logic [23:0]   tab_data,
    output logic [7:0]    i2c_addr,
    output logic [7:0]    i2c_wrdata,
    output logic          i2c_req,
    output logic          i2c_last,
    input  logic          i2c_ack,
    input  logic          i2c_err,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [7:0]    errcnt
);
    localparam int TW = $clog2(255 * DELAY_UNIT + 1);
    localparam int RW = $clog2(RETRIES + 2);
    localparam logic [TW-1:0] DUNIT = TW'(DELAY_UNIT);
    localparam logic [RW-1:0] RLOAD = RW'(RETRIES);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_SENDREG = 4'd3,
        S_WAITREG = 4'd4,
        S_SENDVAL = 4'd5,
        S_WAITVAL = 4'd6,
        S_WAIT    = 4'd7,
        S_NEXT    = 4'd8,
        S_FIN     = 4'd9
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] idx_r, idx_s;
    logic [23:0]   ent_r, ent_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [RW-1:0] retry_r, retry_s;
    logic          tgt_send_r, tgt_send_s;
    logic          auto_r, auto_s;
    logic [7:0]    addr_r, addr_s;
    logic [7:0]    wrdata_r, wrdata_s;
    logic          req_r, req_s;
    logic          last_r, last_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          fail_r, fail_s;
    logic [7:0]    errcnt_r, errcnt_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Next-state and next-output computation.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        ent_s      = ent_r;
        timer_s    = timer_r;
        retry_s    = retry_r;
        tgt_send_s = tgt_send_r;
        auto_s     = auto_r;
        addr_s     = addr_r;
        wrdata_s   = wrdata_r;
        req_s      = 1'b0;
        last_s     = last_r;
        busy_s     = busy_r;
        done_s     = done_r;
        fail_s     = fail_r;
        errcnt_s   = errcnt_r;

        case (state_r)
            S_IDLE: begin
                if (start || auto_r) begin
                    state_s  = S_FETCH;
                    idx_s    = {AW{1'b0}};
                    auto_s   = 1'b0;
                    busy_s   = 1'b1;
                    done_s   = 1'b0;
                    fail_s   = 1'b0;
                    errcnt_s = 8'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: state_s = S_DECODE;
            S_DECODE: begin
                ent_s = tab_data;
                if (tab_data[23:16] == 8'h00) begin
                    state_s = S_FIN;
                end else if (tab_data[23:16] == 8'hFF) begin
                    if (tab_data[7:0] == 8'h00) begin
                        state_s = S_NEXT;
                    end else begin
                        timer_s    = TW'(tab_data[7:0]) * DUNIT;
                        tgt_send_s = 1'b0;
                        state_s    = S_WAIT;
                    end
                end else begin
                    retry_s = RLOAD;
                    state_s = S_SENDREG;
                end
            end
            S_SENDREG: state_s = S_WAITREG;
            S_SENDVAL: state_s = S_WAITVAL;
            S_WAITREG, S_WAITVAL: begin
                // err takes priority over a coincident ack
                if (i2c_err) begin
                    errcnt_s = sat_inc8(errcnt_r);
                    if (retry_r != {RW{1'b0}}) begin
                        retry_s    = retry_r - RW'(1'b1);
                        timer_s    = DUNIT;
                        tgt_send_s = 1'b1;
                        state_s    = S_WAIT;
                    end else begin
                        fail_s  = 1'b1;
                        state_s = S_NEXT;
                    end
                end else if (i2c_ack) begin
                    state_s = (state_r == S_WAITREG) ? S_SENDVAL : S_NEXT;
                end else begin
                    state_s = state_r;
                end
            end
            S_WAIT: begin
                // Leaving on timer==1 makes the stay exactly the loaded count
                if (timer_r <= TW'(1'b1)) begin
                    state_s = tgt_send_r ? S_SENDREG : S_NEXT;
                end else begin
                    timer_s = timer_r - TW'(1'b1);
                end
            end
            S_NEXT: begin
                if (idx_r == {AW{1'b1}}) begin
                    state_s = S_FIN;
                end else begin
                    idx_s   = idx_r + AW'(1'b1);
                    state_s = S_FETCH;
                end
            end
            S_FIN: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase

        // Bus outputs are loaded on entry to a send state so they are valid with i2c_req
        case (state_s)
            S_SENDREG: begin
                addr_s   = ent_s[23:16] & 8'hFE;
                wrdata_s = ent_s[15:8];
                last_s   = 1'b0;
                req_s    = 1'b1;
            end
            S_SENDVAL: begin
                wrdata_s = ent_s[7:0];
                last_s   = 1'b1;
                req_s    = 1'b1;
            end
            default: req_s = 1'b0;
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            idx_r      <= {AW{1'b0}};
            ent_r      <= 24'd0;
            timer_r    <= {TW{1'b0}};
            retry_r    <= {RW{1'b0}};
            tgt_send_r <= 1'b0;
            auto_r     <= (AUTOSTART != 0);
            addr_r     <= 8'd0;
            wrdata_r   <= 8'd0;
            req_r      <= 1'b0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fail_r     <= 1'b0;
            errcnt_r   <= 8'd0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            ent_r      <= ent_s;
            timer_r    <= timer_s;
            retry_r    <= retry_s;
            tgt_send_r <= tgt_send_s;
            auto_r     <= auto_s;
            addr_r     <= addr_s;
            wrdata_r   <= wrdata_s;
            req_r      <= req_s;
            last_r     <= last_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            fail_r     <= fail_s;
            errcnt_r   <= errcnt_s;
        end
    end

    assign tab_addr   = idx_r;
    assign i2c_addr   = addr_r;
    assign i2c_wrdata = wrdata_r;
    assign i2c_req    = req_r;
    assign i2c_last   = last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fail       = fail_r;
    assign errcnt     = errcnt_r;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed self-checking bench for i2c_init_seq with a sync-ROM model and a
// scripted I2C slave that can ACK, NACK, double-pulse or stall.
module tb_i2c_init_seq;
    localparam int AW = 3;
    localparam int RETRIES = 3;
    localparam int DU = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [AW-1:0] tab_addr;
    logic [23:0] tab_data;
    logic [7:0]  i2c_addr, i2c_wrdata, errcnt;
    logic        i2c_req, i2c_last, i2c_ack, i2c_err, busy, done, fail;

    i2c_init_seq #(.AW(AW), .RETRIES(RETRIES), .DELAY_UNIT(DU), .AUTOSTART(1)) dut (
        .clk(clk), .rst(rst), .start(start), .tab_addr(tab_addr), .tab_data(tab_data),
        .i2c_addr(i2c_addr), .i2c_wrdata(i2c_wrdata), .i2c_req(i2c_req), .i2c_last(i2c_last),
        .i2c_ack(i2c_ack), .i2c_err(i2c_err), .busy(busy), .done(done), .fail(fail),
        .errcnt(errcnt)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [0:7];
    always @(posedge clk) tab_data <= rom[tab_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int npass = 0;

    logic [16:0] log_q[$];
    int req_t[$];
    int ack_t[$];
    int err_t[$];
    int pend_cnt = 0;
    bit pend_nack = 1'b0;
    bit pend_both = 1'b0;
    bit slave_hold = 1'b0;
    bit hold_on_last = 1'b0;
    int nack_left = 0;
    logic [7:0] nack_addr = 8'h00;
    int both_left = 0;

    // Slave model: answers each byte two cycles after the request
    initial begin
        i2c_ack = 1'b0;
        i2c_err = 1'b0;
        forever begin
            @(negedge clk);
            i2c_ack = 1'b0;
            i2c_err = 1'b0;
            if (rst) begin
                pend_cnt = 0;
            end else if (pend_cnt > 0 && !slave_hold) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    if (pend_both) begin
                        i2c_ack = 1'b1; i2c_err = 1'b1; err_t.push_back(cyc);
                    end else if (pend_nack) begin
                        i2c_err = 1'b1; err_t.push_back(cyc);
                    end else begin
                        i2c_ack = 1'b1; ack_t.push_back(cyc);
                    end
                end
            end
            if (!rst && i2c_req) begin
                log_q.push_back({i2c_last, i2c_addr, i2c_wrdata});
                req_t.push_back(cyc);
                pend_cnt = 2;
                pend_both = 1'b0;
                pend_nack = 1'b0;
                if (!i2c_last) begin
                    if (both_left > 0) begin
                        pend_both = 1'b1; both_left--;
                    end else if (i2c_addr == nack_addr && nack_left != 0) begin
                        pend_nack = 1'b1;
                        if (nack_left > 0) nack_left--;
                    end
                end
                if (i2c_last && hold_on_last) slave_hold = 1'b1;
            end
        end
    end

    function automatic string log_str();
        string s = "";
        foreach (log_q[i]) s = {s, $sformatf("%05h ", log_q[i])};
        return s;
    endfunction

    task automatic clear_run();
        log_q.delete(); req_t.delete(); ack_t.delete(); err_t.delete();
        nack_left = 0; nack_addr = 8'h00; both_left = 0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 8; i++) rom[i] = 24'h000000;
        rom[0] = 24'h5410AA;
        rom[1] = 24'h3402BB;
    endtask

    task automatic load_delay();
        for (int i = 0; i < 8; i++) rom[i] = 24'h000000;
        rom[0] = 24'h5410AA;
        rom[1] = 24'hFF0003;
        rom[2] = 24'h3402BB;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!(done && !busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        nchk++;
        if (done && !busy) npass++;
        else $display("FAIL %s_timeout: done=%0b busy=%0b after %0d cycles, required done=1 busy=0",
                      name, done, busy, n);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nchk++;
        if ({tab_addr, i2c_addr, i2c_wrdata, i2c_req, i2c_last, busy, done, fail, errcnt} !== 32'd0)
            $display("FAIL reset_values: got %h required 00000000",
                     {tab_addr, i2c_addr, i2c_wrdata, i2c_req, i2c_last, busy, done, fail, errcnt});
        else npass++;
    endtask

    task automatic test_autostart_basic();
        int g1, g2;
        clear_run();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        nchk++;
        if (busy !== 1'b1) $display("FAIL autostart_busy: got %b required 1", busy); else npass++;
        wait_done("basic", 200);
        nchk++;
        if (log_str() != "05410 154aa 03402 134bb ")
            $display("FAIL basic_bus: got '%s' required '05410 154aa 03402 134bb '", log_str());
        else npass++;
        nchk++;
        if ({done, fail, errcnt} !== 10'b1_0_00000000)
            $display("FAIL basic_status: got done/fail/errcnt %b/%b/%0d required 1/0/0", done, fail, errcnt);
        else npass++;
        g1 = (req_t.size() > 1 && ack_t.size() > 0) ? req_t[1] - ack_t[0] : -1;
        g2 = (req_t.size() > 2 && ack_t.size() > 1) ? req_t[2] - ack_t[1] : -1;
        nchk++;
        if (g1 != 1) $display("FAIL val_req_gap: got %0d required 1", g1); else npass++;
        nchk++;
        if (g2 != 4) $display("FAIL entry_gap: got %0d required 4", g2); else npass++;
    endtask

    task automatic test_delay();
        int g;
        clear_run();
        load_delay();
        pulse_start();
        nchk++;
        if ({busy, done} !== 2'b10) $display("FAIL start_busy: got busy/done %b/%b required 1/0", busy, done);
        else npass++;
        wait_done("delay", 500);
        nchk++;
        if (log_str() != "05410 154aa 03402 134bb ")
            $display("FAIL delay_bus: got '%s' required '05410 154aa 03402 134bb '", log_str());
        else npass++;
        g = (req_t.size() > 2 && ack_t.size() > 1) ? req_t[2] - ack_t[1] : -1;
        nchk++;
        if (g != 3 * DU + 7) $display("FAIL delay_gap: got %0d required %0d", g, 3 * DU + 7); else npass++;
    endtask

    task automatic test_start_while_busy();
        int g;
        clear_run();
        load_delay();
        pulse_start();
        repeat (20) @(negedge clk);
        nchk++;
        if (busy !== 1'b1) $display("FAIL busy_mid_run: got %b required 1", busy); else npass++;
        pulse_start();
        wait_done("busy_start", 500);
        nchk++;
        if (log_str() != "05410 154aa 03402 134bb ")
            $display("FAIL busy_start_bus: got '%s' required '05410 154aa 03402 134bb '", log_str());
        else npass++;
        g = (req_t.size() > 2 && ack_t.size() > 1) ? req_t[2] - ack_t[1] : -1;
        nchk++;
        if (g != 3 * DU + 7) $display("FAIL busy_start_gap: got %0d required %0d", g, 3 * DU + 7); else npass++;
    endtask

    task automatic test_retry();
        int g;
        clear_run();
        load_basic();
        nack_addr = 8'h54;
        nack_left = 2;
        pulse_start();
        wait_done("retry", 600);
        nchk++;
        if (log_str() != "05410 05410 05410 154aa 03402 134bb ")
            $display("FAIL retry_bus: got '%s' required '05410 05410 05410 154aa 03402 134bb '", log_str());
        else npass++;
        nchk++;
        if ({done, fail, errcnt} !== {1'b1, 1'b0, 8'd2})
            $display("FAIL retry_status: got done/fail/errcnt %b/%b/%0d required 1/0/2", done, fail, errcnt);
        else npass++;
        g = (req_t.size() > 1 && err_t.size() > 0) ? req_t[1] - err_t[0] : -1;
        nchk++;
        if (g != DU + 1) $display("FAIL retry_gap: got %0d required %0d", g, DU + 1); else npass++;
    endtask

    task automatic test_retry_exhaust();
        clear_run();
        load_basic();
        nack_addr = 8'h54;
        nack_left = -1;
        pulse_start();
        wait_done("exhaust", 800);
        nchk++;
        if (log_str() != "05410 05410 05410 05410 03402 134bb ")
            $display("FAIL exhaust_bus: got '%s' required '05410 05410 05410 05410 03402 134bb '", log_str());
        else npass++;
        nchk++;
        if ({done, fail, errcnt} !== {1'b1, 1'b1, 8'd4})
            $display("FAIL exhaust_status: got done/fail/errcnt %b/%b/%0d required 1/1/4", done, fail, errcnt);
        else npass++;
    endtask

    task automatic test_ack_err_both();
        clear_run();
        load_basic();
        both_left = 1;
        pulse_start();
        nchk++;
        if ({done, fail, errcnt} !== 10'd0)
            $display("FAIL start_clears: got done/fail/errcnt %b/%b/%0d required 0/0/0", done, fail, errcnt);
        else npass++;
        wait_done("both", 600);
        nchk++;
        if (log_str() != "05410 05410 154aa 03402 134bb ")
            $display("FAIL both_bus: got '%s' required '05410 05410 154aa 03402 134bb '", log_str());
        else npass++;
        nchk++;
        if ({done, fail, errcnt} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL both_status: got done/fail/errcnt %b/%b/%0d required 1/0/1", done, fail, errcnt);
        else npass++;
    endtask

    task automatic test_full_table();
        string exp_s = "";
        logic [7:0] d, r, v;
        clear_run();
        for (int i = 0; i < 8; i++) begin
            d = 8'h20 + 8'(i) * 8'd2;
            r = 8'(i);
            v = 8'h80 + 8'(i);
            rom[i] = {d, r, v};
            exp_s = {exp_s, $sformatf("%05h %05h ", {1'b0, d, r}, {1'b1, d, v})};
        end
        pulse_start();
        wait_done("full", 600);
        nchk++;
        if (log_str() != exp_s) $display("FAIL full_bus: got '%s' required '%s'", log_str(), exp_s);
        else npass++;
        nchk++;
        if ({done, fail, errcnt} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL full_status: got done/fail/errcnt %b/%b/%0d required 1/0/0", done, fail, errcnt);
        else npass++;
    endtask

    task automatic test_rst_mid();
        int n = 0;
        clear_run();
        load_basic();
        hold_on_last = 1'b1;
        pulse_start();
        while (!slave_hold && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        nchk++;
        if ({busy, i2c_last} !== 2'b11) $display("FAIL waitval_reached: got busy/last %b/%b required 1/1", busy, i2c_last);
        else npass++;
        rst = 1'b1;
        @(negedge clk);
        nchk++;
        if ({tab_addr, i2c_addr, i2c_wrdata, i2c_req, i2c_last, busy, done, fail, errcnt} !== 32'd0)
            $display("FAIL rst_mid_values: got %h required 00000000",
                     {tab_addr, i2c_addr, i2c_wrdata, i2c_req, i2c_last, busy, done, fail, errcnt});
        else npass++;
        hold_on_last = 1'b0;
        slave_hold = 1'b0;
        clear_run();
        rst = 1'b0;
        @(negedge clk);
        nchk++;
        if (busy !== 1'b1) $display("FAIL rst_autostart_busy: got %b required 1", busy); else npass++;
        wait_done("after_rst", 200);
        nchk++;
        if (log_str() != "05410 154aa 03402 134bb ")
            $display("FAIL after_rst_bus: got '%s' required '05410 154aa 03402 134bb '", log_str());
        else npass++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        load_basic();
        test_reset();
        test_autostart_basic();
        test_delay();
        test_start_while_busy();
        test_retry();
        test_retry_exhaust();
        test_ack_err_both();
        test_full_table();
        test_rst_mid();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/i2c_init_seq.md
# i2c_init_seq

Table-driven I2C configuration sequencer for the video front end. It walks a small external register table of {device address, register, value} entries and issues each entry as a two-byte write through the byte-level I2C master (`i2c`). It also handles delay entries, per-entry retry on NACK and end-of-table detection. It sits between the board-level init ROM and the `i2c` master, and brings up the decoder/encoder chips after reset or on request.

## Interface
Parameters:
- `AW`, 6: table index width; table holds up to 2^AW entries.
- `RETRIES`, 3: extra attempts per entry after a NACK before giving up on that entry.
- `DELAY_UNIT`, 1000: clk cycles per delay-entry tick; also the back-off gap before a retry.
- `AUTOSTART`, 1: 1 = run the table once immediately after reset.

Ports:
- `clk`  in  1  system clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; (re)runs the table from entry 0 when not busy.
- `tab_addr`  out  AW  table index.
- `tab_data`  in  24  entry {dev[23:16], reg[15:8], val[7:0]}; valid 1 cycle after `tab_addr` changes (sync ROM).
- `i2c_addr`  out  8  address byte to the master (7-bit address in [7:1], R/W=0 in bit 0).
- `i2c_wrdata`  out  8  data byte to the master.
- `i2c_req`  out  1  one-cycle pulse: master sends one byte, prefixed by START+address if the bus is idle.
- `i2c_last`  out  1  with `i2c_req`: master issues STOP after this byte.
- `i2c_ack`  in  1  one-cycle pulse: byte accepted by the slave.
- `i2c_err`  in  1  one-cycle pulse: NACK; the master has already released the bus with STOP.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sticky; table completed since the last start.
- `fail`  out  1  sticky; at least one entry was abandoned after exhausting retries.
- `errcnt`  out  8  total NACKs this run; saturates at 255.

## Operation
- States: IDLE, FETCH, DECODE, SENDREG, WAITREG, SENDVAL, WAITVAL, WAIT, NEXT, FIN.
- IDLE: `start` (or the first cycle after reset when AUTOSTART=1) clears `done`, `fail`, `errcnt` and the index, then goes to FETCH.
- FETCH: drive `tab_addr` = index and wait one cycle, then go to DECODE.
- DECODE, based on `dev`:
  - 0x00: end marker, go to FIN.
  - 0xFF: delay entry. Load a timer with `val`*DELAY_UNIT and go to WAIT. `val`=0 means no wait, go straight to NEXT.
  - Otherwise: load the retry counter with RETRIES and go to SENDREG.
- SENDREG:
  - Drive `i2c_addr`={dev[7:1],1'b0}, `i2c_wrdata`=reg, `i2c_last`=0.
  - Pulse `i2c_req` for one cycle, then go to WAITREG.
- WAITREG: `i2c_ack` goes to SENDVAL; `i2c_err` goes to the retry path.
- SENDVAL: drive `i2c_wrdata`=val, `i2c_last`=1, pulse `i2c_req`, then go to WAITVAL.
- WAITVAL: `i2c_ack` goes to NEXT; `i2c_err` goes to the retry path.
- Retry path:
  - `errcnt` +1 (saturating).
  - If the retry counter is nonzero: decrement it, load the timer with DELAY_UNIT, go to WAIT, then return to SENDREG. The whole entry is resent.
  - If it is zero: set `fail` and go to NEXT. The entry is skipped.
- WAIT: count the timer down to 0, then go to the pending target (NEXT or SENDREG).
- NEXT: if index = 2^AW-1, go to FIN (implicit end); otherwise index +1 and go to FETCH.
- FIN: set `done`, clear `busy`, go to IDLE.
- `start` while busy is ignored.
- If `i2c_ack` and `i2c_err` arrive in the same cycle, err wins.
- `i2c_ack`/`i2c_err` outside WAITREG/WAITVAL are ignored.
- Timer width is sized for 255*DELAY_UNIT; no overflow.

## Timing
- Reset values: `tab_addr`=0, `i2c_addr`=0, `i2c_wrdata`=0, `i2c_req`=0, `i2c_last`=0, `busy`=0, `done`=0, `fail`=0, `errcnt`=0; state IDLE.
- `rst` mid-operation aborts immediately to the reset values. The `i2c` master shares `rst`, so no bus recovery is needed here.
- `busy` rises the cycle after the `start` pulse (or the cycle after reset deasserts with AUTOSTART=1).
- FETCH→DECODE takes 2 cycles from the `tab_addr` update; `tab_data` is sampled in DECODE only.
- `i2c_addr`, `i2c_wrdata` and `i2c_last` are valid in the `i2c_req` cycle and held stable until the matching ack/err.
- The next `i2c_req` comes exactly 1 cycle after the `i2c_ack` of the reg byte, so the master never goes idle mid-transaction.
- Retry resend: `i2c_req` is asserted DELAY_UNIT+1 cycles after `i2c_err`.
- `done` rises in the cycle after FIN is entered, at the same edge where `busy` falls.

## Test plan
- Table {0x5410AA},{0x3402BB},{0x000000} with slave model ACKing all bytes:
  - Bus carries 0x54,0x10,0xAA,STOP and then 0x34,0x02,0xBB,STOP.
  - `done`=1, `fail`=0, `errcnt`=0.
- Delay entry {0xFF0003} between two writes:
  - The second write's `i2c_req` follows the first's final `i2c_ack` by 3*DELAY_UNIT + fixed overhead (±0).
- Slave NACKs the first 2 attempts at 0x54, then ACKs:
  - Entry is sent 3 times; `errcnt`=2, `fail`=0, `done`=1.
- Slave always NACKs 0x54, RETRIES=3:
  - 4 attempts are made, then the next entry runs; `fail`=1, `errcnt`=4, `done`=1.
- Table full of writes with no end marker (2^AW entries): exactly 2^AW transactions, then `done`=1.
- Protocol edge cases:
  - `rst` pulsed during WAITVAL forces all outputs to their reset values the next cycle.
  - `start` pulsed while busy has no effect.
  - Simultaneous `i2c_ack`+`i2c_err` is treated as a NACK.
